// File: rtl/sevenseg_scan_decoder_if.sv
// Bus between a multiplexed seven-segment display driver and its read-back decoder.
// The driver side (master) owns segments/digit_en; the decoder side (slave) owns the result.
interface sevenseg_scan_decoder_if #(
  parameter int NDIG = 4
);
  logic [6:0]        segments;
  logic [NDIG-1:0]   digit_en;
  logic [4*NDIG-1:0] value;
  logic              value_valid;
  logic              value_err;

  modport master (
    output segments,
    output digit_en,
    input  value,
    input  value_valid,
    input  value_err
  );

  modport slave (
    input  segments,
    input  digit_en,
    output value,
    output value_valid,
    output value_err
  );
endinterface

// File: rtl/sevenseg_scan_decoder.sv
// Reads a scanned seven-segment display back into BCD: each stable one-hot digit
// pattern is decoded into a shadow word, and the whole word is published once every position is seen.
module sevenseg_scan_decoder #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sevenseg_scan_decoder_if.slave bus
);

  localparam int             CW      = $clog2(STABLE_CYC + 1);
  localparam int             IW      = 7 + NDIG;
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYC);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [NDIG-1:0] MASK_FULL = {NDIG{1'b1}};

  // Returns {illegal, nibble}; anything that is not a digit glyph maps to F.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: seg_decode = {1'b0, 4'h0};
      7'b0110000: seg_decode = {1'b0, 4'h1};
      7'b1101101: seg_decode = {1'b0, 4'h2};
      7'b1111001: seg_decode = {1'b0, 4'h3};
      7'b0110011: seg_decode = {1'b0, 4'h4};
      7'b1011011: seg_decode = {1'b0, 4'h5};
      7'b1011111: seg_decode = {1'b0, 4'h6};
      7'b1110000: seg_decode = {1'b0, 4'h7};
      7'b1111111: seg_decode = {1'b0, 4'h8};
      7'b1110011: seg_decode = {1'b0, 4'h9};
      default:    seg_decode = {1'b1, 4'hF};
    endcase
  endfunction

  logic [IW-1:0]     in_s;
  logic              same_s;
  logic              onehot_s;
  logic              capture_s;
  logic [4:0]        dec_s;

  logic [IW-1:0]     prev_q,   prev_d;
  logic [CW-1:0]     cnt_q,    cnt_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [NDIG-1:0]   serr_q,   serr_d;
  logic [NDIG-1:0]   mask_q,   mask_d;
  logic [4*NDIG-1:0] value_q,  value_d;
  logic              valid_q,  valid_d;
  logic              verr_q,   verr_d;

  assign in_s     = {bus.segments, bus.digit_en};
  assign same_s   = (in_s == prev_q);
  assign onehot_s = $onehot(bus.digit_en);
  assign dec_s    = seg_decode(bus.segments);

  // Stability counting, capture into the shadow word and frame publication.
  always_comb begin
    prev_d   = in_s;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    serr_d   = serr_q;
    mask_d   = mask_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    verr_d   = verr_q;

    if (same_s) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ONE;
    end

    // A held input sits saturated at CNT_MAX; only the arrival there captures.
    capture_s = onehot_s && (cnt_d == CNT_MAX) && !(same_s && (cnt_q == CNT_MAX));

    for (int i = 0; i < NDIG; i++) begin
      if (capture_s && bus.digit_en[i]) begin
        shadow_d[4*i +: 4] = dec_s[3:0];
        serr_d[i]          = dec_s[4];
        mask_d[i]          = 1'b1;
      end else begin
        shadow_d[4*i +: 4] = shadow_q[4*i +: 4];
        serr_d[i]          = serr_q[i];
        mask_d[i]          = mask_q[i];
      end
    end

    if (capture_s && (mask_d == MASK_FULL)) begin
      value_d = shadow_d;
      verr_d  = |serr_d;
      valid_d = 1'b1;
      mask_d  = {NDIG{1'b0}};
    end else begin
      value_d = value_q;
      verr_d  = verr_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q   <= {IW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      shadow_q <= {(4*NDIG){1'b0}};
      serr_q   <= {NDIG{1'b0}};
      mask_q   <= {NDIG{1'b0}};
      value_q  <= {(4*NDIG){1'b0}};
      valid_q  <= 1'b0;
      verr_q   <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      serr_q   <= serr_d;
      mask_q   <= mask_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      verr_q   <= verr_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = valid_q;
  assign bus.value_err   = verr_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Drives identical scans into a STABLE_CYC=3 and a STABLE_CYC=1 decoder and compares
// both against a run-length reference model plus directed expectations.
module tb_sevenseg_scan_decoder;

  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sevenseg_scan_decoder_if #(.NDIG(ND)) bus0 ();
  sevenseg_scan_decoder_if #(.NDIG(ND)) bus1 ();

  sevenseg_scan_decoder #(.NDIG(ND), .STABLE_CYC(3)) dut0 (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus0)
  );

  sevenseg_scan_decoder #(.NDIG(ND), .STABLE_CYC(1)) dut1 (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus1)
  );

  int checks = 0;
  int errors = 0;
  int stepno = 0;
  int pulses [2];
  int last_pulse [2];
  int sv [2] = '{3, 1};

  logic [6:0]  pat [10];
  logic [10:0] m_prev [2];
  int          m_run [2];
  logic [3:0]  m_dig [2][ND];
  logic        m_derr [2][ND];
  logic        m_cap [2][ND];
  logic [15:0] m_val [2];
  logic        m_verr [2];
  logic        m_valid [2];

  function automatic int digit_of(input logic [6:0] seg);
    for (int i = 0; i < 10; i++) begin
      if (pat[i] == seg) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count how long the input has been unchanged; capture when that run equals S.
  task automatic model_step(input int k, input logic [6:0] seg, input logic [3:0] en, input logic rn);
    int  d;
    int  pos;
    logic all;
    if (!rn) begin
      m_prev[k] = '0; m_run[k] = 0; m_val[k] = '0; m_verr[k] = 1'b0; m_valid[k] = 1'b0;
      for (int i = 0; i < ND; i++) begin
        m_dig[k][i] = '0; m_derr[k][i] = 1'b0; m_cap[k][i] = 1'b0;
      end
    end else begin
      m_valid[k] = 1'b0;
      if ({seg, en} == m_prev[k]) m_run[k]++;
      else m_run[k] = 1;
      m_prev[k] = {seg, en};
      if (m_run[k] == sv[k] && $countones(en) == 1) begin
        pos = 0;
        for (int i = 0; i < ND; i++) if (en[i]) pos = i;
        d = digit_of(seg);
        m_dig[k][pos]  = (d < 0) ? 4'hF : 4'(d);
        m_derr[k][pos] = (d < 0);
        m_cap[k][pos]  = 1'b1;
        all = 1'b1;
        for (int i = 0; i < ND; i++) all &= m_cap[k][i];
        if (all) begin
          m_verr[k] = 1'b0;
          for (int i = 0; i < ND; i++) begin
            m_val[k][4*i +: 4] = m_dig[k][i];
            m_verr[k] |= m_derr[k][i];
            m_cap[k][i] = 1'b0;
          end
          m_valid[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic [6:0] seg, input logic [3:0] en, input logic rn);
    bus0.segments = seg; bus0.digit_en = en;
    bus1.segments = seg; bus1.digit_en = en;
    rst_n = rn;
    @(posedge clk);
    #1;
    model_step(0, seg, en, rn);
    model_step(1, seg, en, rn);
    chk("s3_value", 32'(bus0.value), 32'(m_val[0]));
    chk("s3_valid", 32'(bus0.value_valid), 32'(m_valid[0]));
    chk("s3_err",   32'(bus0.value_err), 32'(m_verr[0]));
    chk("s1_value", 32'(bus1.value), 32'(m_val[1]));
    chk("s1_valid", 32'(bus1.value_valid), 32'(m_valid[1]));
    chk("s1_err",   32'(bus1.value_err), 32'(m_verr[1]));
    if (bus0.value_valid === 1'b1) begin pulses[0]++; last_pulse[0] = stepno; end
    if (bus1.value_valid === 1'b1) begin pulses[1]++; last_pulse[1] = stepno; end
    stepno++;
  endtask

  task automatic hold(input logic [6:0] seg, input logic [3:0] en, input int n);
    repeat (n) step(seg, en, 1'b1);
  endtask

  initial begin
    int t;
    int p0;
    int p1;
    logic [6:0] seg;
    logic [3:0] en;
    int r;

    pat = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};
    pulses = '{0, 0};
    last_pulse = '{-1, -1};
    rst_n = 1'b0;
    bus0.segments = '0; bus0.digit_en = '0;
    bus1.segments = '0; bus1.digit_en = '0;

    step(7'b0, 4'b0, 1'b0);
    step(7'b0, 4'b0, 1'b0);
    chk("reset_value", 32'(bus0.value), 32'h0);
    chk("reset_valid", 32'(bus0.value_valid), 32'h0);

    // 1: one clean frame 4321
    t = stepno;
    for (int p = 0; p < 4; p++) hold(pat[p + 1], 4'(1 << p), 5);
    chk("t1_value_s3", 32'(bus0.value), 32'h4321);
    chk("t1_err_s3", 32'(bus0.value_err), 32'h0);
    chk("t1_pulses_s3", 32'(pulses[0]), 32'd1);
    chk("t1_when_s3", 32'(last_pulse[0]), 32'(t + 17));
    chk("t1_value_s1", 32'(bus1.value), 32'h4321);
    chk("t1_when_s1", 32'(last_pulse[1]), 32'(t + 15));

    // 2: position 1 too short, frame stays open until it is shown long enough
    p0 = pulses[0];
    hold(pat[6], 4'b0001, 5);
    hold(pat[7], 4'b0010, 2);
    hold(7'b0, 4'b0000, 3);
    hold(pat[0], 4'b0100, 5);
    hold(pat[9], 4'b1000, 5);
    chk("t2_novalid_s3", 32'(pulses[0] - p0), 32'd0);
    hold(pat[5], 4'b0010, 5);
    chk("t2_value_s3", 32'(bus0.value), 32'h9056);
    chk("t2_pulse_s3", 32'(pulses[0] - p0), 32'd1);

    // 3: blank position flags an error; next clean frame clears it
    hold(pat[8], 4'b0001, 5);
    hold(pat[8], 4'b0010, 5);
    hold(7'b0, 4'b0100, 5);
    hold(pat[8], 4'b1000, 5);
    chk("t3_value_s3", 32'(bus0.value), 32'h8F88);
    chk("t3_err_s3", 32'(bus0.value_err), 32'h1);
    chk("t3_value_s1", 32'(bus1.value), 32'h8F88);
    for (int p = 0; p < 4; p++) hold(pat[9], 4'(1 << p), 5);
    chk("t3_clean_s3", 32'(bus0.value), 32'h9999);
    chk("t3_clean_err_s3", 32'(bus0.value_err), 32'h0);

    // 4: multi-hot and zero enables never capture
    p0 = pulses[0]; p1 = pulses[1];
    hold(pat[3], 4'b0011, 10);
    hold(pat[3], 4'b0000, 5);
    chk("t4_novalid_s3", 32'(pulses[0] - p0), 32'd0);
    chk("t4_novalid_s1", 32'(pulses[1] - p1), 32'd0);

    // 5: reset discards a partial frame
    hold(pat[5], 4'b0001, 5);
    hold(pat[5], 4'b0010, 5);
    p0 = pulses[0]; p1 = pulses[1];
    step(pat[5], 4'b0100, 1'b0);
    chk("t5_rst_value_s3", 32'(bus0.value), 32'h0);
    chk("t5_rst_value_s1", 32'(bus1.value), 32'h0);
    for (int p = 0; p < 4; p++) hold(pat[5], 4'(1 << p), 5);
    chk("t5_value_s3", 32'(bus0.value), 32'h5555);
    chk("t5_pulse_s3", 32'(pulses[0] - p0), 32'd1);
    chk("t5_pulse_s1", 32'(pulses[1] - p1), 32'd1);

    // 6: continuous scan, last position held long
    p0 = pulses[0]; p1 = pulses[1];
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 4; p++) begin
        hold(pat[$urandom_range(0, 9)], 4'(1 << p), (f == 2 && p == 3) ? 100 : 4);
      end
    end
    chk("t6_pulses_s3", 32'(pulses[0] - p0), 32'd3);
    chk("t6_pulses_s1", 32'(pulses[1] - p1), 32'd3);

    // Random scan traffic against the model, with occasional resets and bad enables
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      seg = (r < 8) ? pat[$urandom_range(0, 9)] : 7'($urandom);
      r = $urandom_range(0, 19);
      if (r < 15) en = 4'(1 << $urandom_range(0, 3));
      else if (r < 17) en = 4'b0000;
      else en = 4'($urandom);
      if (r == 19) step(seg, en, 1'b0);
      else hold(seg, en, $urandom_range(1, 5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_decoder.md
Name: sevenseg_scan_decoder

Overview:
- Reader for the multiplexed seven-segment display bus. Samples the segment lines (abc_defg, active-high) together with the active-high one-hot digit-enable lines, and decodes each stable pattern back to a BCD nibble.
- Assembles one nibble per digit position into a packed word and pulses valid once every position has been captured.
- Used as a loopback checker on the display path and as a front end for reading scanned displays back into the datapath.

Parameters:
NDIG, 4, number of multiplexed digit positions (1..8)
STABLE_CYC, 3, consecutive identical cycles required before a capture (>=1)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous, active-low reset; sampled on rising edge of clk
segments  input  7  segment pattern, bit6=a ... bit0=g, 1=lit
digit_en  input  NDIG  active-high digit select; bit i = position i
value  output  4*NDIG  decoded digits; position i at value[4i+3:4i]
value_valid  output  1  one-cycle pulse: value/value_err updated
value_err  output  1  at least one nibble of current value was an illegal pattern

Behaviour:
- Reset (reset_n=0 at an edge): value=0, value_valid=0, value_err=0, capture mask=0, shadow nibbles=0, shadow err bits=0, stability count=0, previous-input register=0. Any partial frame is discarded.
- Input register: each edge stores {segments,digit_en} into prev.
- Stability count: if current {segments,digit_en} == prev, then cnt <= min(cnt+1, STABLE_CYC); else cnt <= 1. Width = clog2(STABLE_CYC+1).
- Capture: occurs on the edge where cnt transitions to STABLE_CYC, only if digit_en is exactly one-hot. A new input first present in cycle t0 and held is therefore captured at the edge ending cycle t0+STABLE_CYC-1.
  - Saturation guarantees one capture per stable run; a held input is never recaptured.
  - digit_en zero or multi-hot: no capture, count still runs.
- Capture action for position i: shadow[i] <= decode(segments); shadow_err[i] <= illegal; mask[i] <= 1. Recapturing position i before the frame completes overwrites shadow[i] (latest wins).
- Decode (abc_defg -> nibble):
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4
  - 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1110011->9
  - Any other pattern, including blank 0000000 -> 4'hF with illegal=1.
- Frame completion: on the same edge where a capture makes mask all-ones:
  - value <= packed shadow, including the nibble just captured.
  - value_err <= OR of all shadow_err bits, including the new one.
  - value_valid <= 1 for exactly one cycle; mask <= 0.
  - Visible in cycle t0+STABLE_CYC.
- value and value_err hold between frames. value_valid is 0 on every other cycle.
- Order of digit positions within a frame is irrelevant.
- Simultaneous events: a capture and frame completion on the same edge is normal. Frame clear and new capture cannot coincide, since there is at most one capture per edge.
- Reset has priority over all other updates.

Test Plan:
1. STABLE_CYC=3. Positions 0..3 show 0110000, 1101101, 1111001, 0110011, each held 5 cycles -> value=16'h4321, value_err=0, value_valid high exactly 1 cycle, in the cycle after position 3's third stable cycle.
2. Position 1 pattern held only 2 cycles, then digit_en=0 -> no capture; mask bit 1 stays 0; no value_valid even after positions 0, 2 and 3 are captured.
3. Frame with position 2 blank (0000000) and other positions showing 8 -> value=16'h8F88, value_err=1. Next clean frame of 9s -> value=16'h9999, value_err=0.
4. digit_en=4'b0011 held 10 cycles with a legal pattern -> no capture, no valid. digit_en=0 -> no capture.
5. Capture positions 0 and 1, then assert reset_n=0 for 1 cycle -> value=0, no valid. Next full frame of 5s -> value=16'h5555 with a single valid pulse.
6. Continuous scan, 4 positions x 4 cycles each, repeated 3 frames, with position 3 held 100 cycles in the last frame -> exactly 3 value_valid pulses and one capture per position per frame. Repeat with STABLE_CYC=1 -> capture occurs on the first edge of each new input.
